// File: rtl/add_sub_pkg.sv
// Shared widths and payload types for the floating-point add/sub exponent-align pipeline.
package add_sub_pkg;

  localparam int unsigned SIZE_MAN = 24;
  localparam int unsigned SIZE_EXP = 8;

  typedef struct packed {
    logic                sign;
    logic [SIZE_EXP-1:0] exp;
    logic [SIZE_MAN-1:0] man;
  } operand_t;

  // Stage-1 result: operands already ordered max/min, with the alignment distance precomputed.
  typedef struct packed {
    logic                sign_max;
    logic                sign_min;
    logic                ezero_max;
    logic                ezero_min;
    logic [SIZE_EXP-1:0] exp_max;
    logic [SIZE_EXP-1:0] shift;
    logic [SIZE_MAN-1:0] man_max;
    logic [SIZE_MAN-1:0] man_min;
  } s1_payload_t;

endpackage

// File: rtl/add_sub_sticky_shift.sv
// Combinational right shifter that also reports the OR of every bit shifted out (sticky).
module add_sub_sticky_shift #(
  parameter int unsigned SIZE_MAN   = 24,
  parameter int unsigned SIZE_SHIFT = 8
) (
  input  logic [SIZE_MAN-1:0]   man_i,
  input  logic [SIZE_SHIFT-1:0] shift_i,
  output logic [SIZE_MAN-1:0]   man_o,
  output logic                  sticky_o
);

  logic [SIZE_MAN-1:0] lost_mask;

  always_comb begin
    lost_mask = ~({SIZE_MAN{1'b1}} << shift_i);
    if (32'(shift_i) >= SIZE_MAN) begin
      man_o    = '0;
      sticky_o = |man_i;
    end else begin
      man_o    = man_i >> shift_i;
      sticky_o = |(man_i & lost_mask);
    end
  end

endmodule

// File: rtl/add_sub_exp_align.sv
// Two-stage exponent compare/swap and mantissa alignment ahead of an FP adder.
// Define ADD_SUB_ALIGN_SUBNORM_EN to treat exponent-0 operands as subnormals instead of zero.
module add_sub_exp_align #(
  parameter int unsigned SIZE_MAN = add_sub_pkg::SIZE_MAN,
  parameter int unsigned SIZE_EXP = add_sub_pkg::SIZE_EXP,
  parameter int unsigned NUM_OP   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [SIZE_EXP+SIZE_MAN-1:0] i_data_a,
  input  logic [SIZE_EXP+SIZE_MAN-1:0] i_data_b,
  input  logic [NUM_OP-1:0]          i_fpu_op,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [NUM_OP-1:0]          o_fpu_op,
  output logic                       o_sign_a,
  output logic                       o_sign_b,
  output logic [SIZE_EXP-1:0]        o_exp_max,
  output logic [SIZE_MAN-1:0]        o_man_max,
  output logic [SIZE_MAN-1:0]        o_man_min,
  output logic                       o_carry,
  output logic                       o_E_zero_A,
  output logic                       o_E_zero_B
);
  import add_sub_pkg::*;

  localparam int unsigned DW = SIZE_EXP + SIZE_MAN;

  function automatic operand_t unpack_op(input logic [DW-1:0] d);
    operand_t o;
    logic     ez;
    ez     = (d[DW-2 -: SIZE_EXP] == '0);
    o.sign = d[DW-1];
`ifdef ADD_SUB_ALIGN_SUBNORM_EN
    o.exp  = ez ? SIZE_EXP'(1) : d[DW-2 -: SIZE_EXP];
    o.man  = {~ez, d[SIZE_MAN-2:0]};
`else
    o.exp  = d[DW-2 -: SIZE_EXP];
    o.man  = ez ? '0 : {1'b1, d[SIZE_MAN-2:0]};
`endif
    return o;
  endfunction

  operand_t    op_a, op_b, op_max, op_min;
  logic        ez_a, ez_b, a_is_max;
  s1_payload_t s1_in, s1_d, s1_q;
  logic [NUM_OP-1:0] s1_op_d, s1_op_q, s2_op_d, s2_op_q;
  logic        s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic        s1_adv, s2_adv;

  logic [SIZE_MAN-1:0] shifted;
  logic                sticky;
  logic                sign_max_d, sign_max_q, sign_min_d, sign_min_q;
  logic                ez_max_d, ez_max_q, ez_min_d, ez_min_q, carry_d, carry_q;
  logic [SIZE_EXP-1:0] exp_max_d, exp_max_q;
  logic [SIZE_MAN-1:0] man_max_d, man_max_q, man_min_d, man_min_q;

  // A stage may load whenever its downstream neighbour frees up; o_ready never depends on i_valid.
  assign s2_adv  = !s2_valid_q || i_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign o_ready = s1_adv;

  always_comb begin
    op_a     = unpack_op(i_data_a);
    op_b     = unpack_op(i_data_b);
    ez_a     = (i_data_a[DW-2 -: SIZE_EXP] == '0);
    ez_b     = (i_data_b[DW-2 -: SIZE_EXP] == '0);
    a_is_max = (op_a.exp > op_b.exp) || ((op_a.exp == op_b.exp) && (op_a.man >= op_b.man));
    op_max   = a_is_max ? op_a : op_b;
    op_min   = a_is_max ? op_b : op_a;

    s1_in.sign_max  = op_max.sign;
    s1_in.sign_min  = op_min.sign;
    s1_in.ezero_max = a_is_max ? ez_a : ez_b;
    s1_in.ezero_min = a_is_max ? ez_b : ez_a;
    s1_in.exp_max   = op_max.exp;
    s1_in.shift     = op_max.exp - op_min.exp;
    s1_in.man_max   = op_max.man;
    s1_in.man_min   = op_min.man;

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s1_op_d    = s1_op_q;
    if (s1_adv) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_d    = s1_in;
        s1_op_d = i_fpu_op;
      end
    end
  end

  add_sub_sticky_shift #(
    .SIZE_MAN  (SIZE_MAN),
    .SIZE_SHIFT(SIZE_EXP)
  ) u_shift (
    .man_i   (s1_q.man_min),
    .shift_i (s1_q.shift),
    .man_o   (shifted),
    .sticky_o(sticky)
  );

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_op_d    = s2_op_q;
    sign_max_d = sign_max_q;
    sign_min_d = sign_min_q;
    ez_max_d   = ez_max_q;
    ez_min_d   = ez_min_q;
    exp_max_d  = exp_max_q;
    man_max_d  = man_max_q;
    man_min_d  = man_min_q;
    carry_d    = carry_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_op_d    = s1_op_q;
        sign_max_d = s1_q.sign_max;
        sign_min_d = s1_q.sign_min;
        ez_max_d   = s1_q.ezero_max;
        ez_min_d   = s1_q.ezero_min;
        exp_max_d  = s1_q.exp_max;
        man_max_d  = s1_q.man_max;
        man_min_d  = shifted;
        carry_d    = sticky;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_op_q    <= '0;
      sign_max_q <= 1'b0;
      sign_min_q <= 1'b0;
      ez_max_q   <= 1'b0;
      ez_min_q   <= 1'b0;
      exp_max_q  <= '0;
      man_max_q  <= '0;
      man_min_q  <= '0;
      carry_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_op_q    <= s2_op_d;
      sign_max_q <= sign_max_d;
      sign_min_q <= sign_min_d;
      ez_max_q   <= ez_max_d;
      ez_min_q   <= ez_min_d;
      exp_max_q  <= exp_max_d;
      man_max_q  <= man_max_d;
      man_min_q  <= man_min_d;
      carry_q    <= carry_d;
    end
  end

  assign o_valid    = s2_valid_q;
  assign o_fpu_op   = s2_op_q;
  assign o_sign_a   = sign_max_q;
  assign o_sign_b   = sign_min_q;
  assign o_exp_max  = exp_max_q;
  assign o_man_max  = man_max_q;
  assign o_man_min  = man_min_q;
  assign o_carry    = carry_q;
  assign o_E_zero_A = ez_max_q;
  assign o_E_zero_B = ez_min_q;

endmodule

// File: tb/tb_add_sub_exp_align.sv
// Directed self-checking bench for add_sub_exp_align (default widths).
module tb_add_sub_exp_align;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_ready, o_ready, o_valid;
  logic [31:0] i_data_a, i_data_b;
  logic [0:0]  i_fpu_op, o_fpu_op;
  logic        o_sign_a, o_sign_b, o_carry, o_E_zero_A, o_E_zero_B;
  logic [7:0]  o_exp_max;
  logic [23:0] o_man_max, o_man_min;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  add_sub_exp_align #(.SIZE_MAN(24), .SIZE_EXP(8), .NUM_OP(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_fpu_op(i_fpu_op),
    .o_valid(o_valid), .i_ready(i_ready), .o_fpu_op(o_fpu_op),
    .o_sign_a(o_sign_a), .o_sign_b(o_sign_b), .o_exp_max(o_exp_max),
    .o_man_max(o_man_max), .o_man_min(o_man_min), .o_carry(o_carry),
    .o_E_zero_A(o_E_zero_A), .o_E_zero_B(o_E_zero_B)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction with i_ready=1; returns #1 after the edge where o_valid should rise.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic op);
    i_data_a = a; i_data_b = b; i_fpu_op = op; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("latency_not_early", {31'd0, o_valid}, 32'd0);
    @(posedge i_clk); #1;
    chk("latency_2", {31'd0, o_valid}, 32'd1);
  endtask

  logic [31:0] bp_a [4];
  logic [7:0]  bp_exp [4];
  logic [23:0] bp_min [4];
  logic [23:0] snap_min;
  logic [7:0]  snap_exp;
  int acc, outs, stall;
  logic fire, seen_drop;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_data_a = '0; i_data_b = '0; i_fpu_op = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_man_max", {8'd0, o_man_max}, 32'd0);
    chk("rst_exp_max", {24'd0, o_exp_max}, 32'd0);
    chk("rst_carry", {31'd0, o_carry}, 32'd0);

    // Basic swap: B (2.0) is larger than A (1.0)
    run_one(32'h3F800000, 32'h40000000, 1'b1);
    chk("swap_exp_max", {24'd0, o_exp_max}, 32'h80);
    chk("swap_man_max", {8'd0, o_man_max}, 32'h800000);
    chk("swap_man_min", {8'd0, o_man_min}, 32'h400000);
    chk("swap_carry", {31'd0, o_carry}, 32'd0);
    chk("swap_sign_a", {31'd0, o_sign_a}, 32'd0);
    chk("swap_fpu_op", {31'd0, o_fpu_op}, 32'd1);

    run_one(32'h3F800001, 32'h40000000, 1'b0);
    chk("sticky_man_min", {8'd0, o_man_min}, 32'h400000);
    chk("sticky_carry", {31'd0, o_carry}, 32'd1);
    chk("sticky_fpu_op", {31'd0, o_fpu_op}, 32'd0);

    run_one(32'h4B800000, 32'h3F800000, 1'b0);
    chk("sat_exp_max", {24'd0, o_exp_max}, 32'h97);
    chk("sat_man_min", {8'd0, o_man_min}, 32'd0);
    chk("sat_carry", {31'd0, o_carry}, 32'd1);

    run_one(32'h3F800000, 32'h3F800000, 1'b0);
    chk("eq_man_min", {8'd0, o_man_min}, 32'h800000);
    chk("eq_carry", {31'd0, o_carry}, 32'd0);

    // Signs follow the swap: negative A is max, positive B is min
    run_one(32'hC0800000, 32'h3F800000, 1'b0);
    chk("sign_max_neg", {31'd0, o_sign_a}, 32'd1);
    chk("sign_min_pos", {31'd0, o_sign_b}, 32'd0);
    chk("sign_man_min", {8'd0, o_man_min}, 32'h200000);

    run_one(32'h00000001, 32'h00800000, 1'b0);
    chk("sub_man_max", {8'd0, o_man_max}, 32'h800000);
    chk("sub_ezero_a", {31'd0, o_E_zero_A}, 32'd0);
    chk("sub_ezero_b", {31'd0, o_E_zero_B}, 32'd1);
    chk("sub_carry", {31'd0, o_carry}, 32'd0);
`ifdef ADD_SUB_ALIGN_SUBNORM_EN
    chk("sub_man_min", {8'd0, o_man_min}, 32'h000001);
`else
    chk("sub_man_min", {8'd0, o_man_min}, 32'd0);
`endif

    // Backpressure: four pairs, B=1.0 and A exponent 128..131
    bp_a[0] = 32'h40000000; bp_exp[0] = 8'h80; bp_min[0] = 24'h400000;
    bp_a[1] = 32'h40800000; bp_exp[1] = 8'h81; bp_min[1] = 24'h200000;
    bp_a[2] = 32'h41000000; bp_exp[2] = 8'h82; bp_min[2] = 24'h100000;
    bp_a[3] = 32'h41800000; bp_exp[3] = 8'h83; bp_min[3] = 24'h080000;
    @(posedge i_clk); #1;
    i_ready = 1'b0; acc = 0; outs = 0; stall = 0; seen_drop = 1'b0;
    i_data_a = bp_a[0]; i_data_b = 32'h3F800000; i_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && outs < 4; cyc++) begin
      @(negedge i_clk);
      if (o_valid) begin
        if (!i_ready) begin
          if (stall == 0) begin
            snap_min = o_man_min; snap_exp = o_exp_max;
          end else begin
            chk("bp_stable_man_min", {8'd0, o_man_min}, {8'd0, snap_min});
            chk("bp_stable_exp_max", {24'd0, o_exp_max}, {24'd0, snap_exp});
          end
          stall++;
        end else begin
          chk("bp_order_exp", {24'd0, o_exp_max}, {24'd0, bp_exp[outs]});
          chk("bp_order_man_min", {8'd0, o_man_min}, {8'd0, bp_min[outs]});
          outs++;
        end
      end
      if (!o_ready && !seen_drop) begin
        chk("bp_ready_drop_after_2", acc, 32'd2);
        seen_drop = 1'b1;
      end
      fire = i_valid && o_ready;
      @(posedge i_clk); #1;
      if (fire) begin
        acc++;
        if (acc < 4) i_data_a = bp_a[acc];
        else i_valid = 1'b0;
      end
      if (stall >= 3) i_ready = 1'b1;
    end
    chk("bp_all_out", outs, 32'd4);
    chk("bp_all_in", acc, 32'd4);
    chk("bp_saw_drop", {31'd0, seen_drop}, 32'd1);
    @(negedge i_clk);
    chk("bp_no_dup", {31'd0, o_valid}, 32'd0);

    // Reset mid-flight: two pairs in flight under backpressure, then reset
    @(posedge i_clk); #1;
    i_ready = 1'b0; i_valid = 1'b1;
    i_data_a = 32'h40000000; i_data_b = 32'h3F800000;
    repeat (2) @(posedge i_clk);
    #1 i_valid = 1'b0;
    chk("rstmf_inflight", {31'd0, o_valid}, 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("rstmf_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rstmf_o_ready", {31'd0, o_ready}, 32'd1);
    chk("rstmf_man_min", {8'd0, o_man_min}, 32'd0);
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk); #1;
      chk("rstmf_no_stale", {31'd0, o_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
